// File: rtl/fft_mult_block_seq.sv
// Radix-4 twiddle-multiply stage: Y0 = X0, Yk = round(Xk*Wk) for k=1..3 via one shared complex multiplier.
// Define FFT_MULT_SAT_EN to clamp narrowed results; otherwise results wrap to D_BIT bits.
module fft_mult_block_seq #(
    parameter int D_BIT   = 17,
    parameter int W_BIT   = 12,
    parameter int W_SHIFT = W_BIT - 2
) (
    input  logic                 iCLK,
    input  logic                 iRESET,
    input  logic                 iVALID,
    output logic                 oREADY,
    input  logic [4*D_BIT-1:0]   iX_RE,
    input  logic [4*D_BIT-1:0]   iX_IM,
    input  logic [3*W_BIT-1:0]   iW_RE,
    input  logic [3*W_BIT-1:0]   iW_IM,
    output logic                 oVALID,
    input  logic                 iREADY,
    output logic [4*D_BIT-1:0]   oY_RE,
    output logic [4*D_BIT-1:0]   oY_IM
);

    localparam int FULL = D_BIT + W_BIT + 1;
    localparam logic signed [FULL-1:0] RND = FULL'(1) <<< (W_SHIFT - 1);
`ifdef FFT_MULT_SAT_EN
    localparam logic signed [FULL-1:0] SAT_MAX = (FULL'(1) <<< (D_BIT - 1)) - FULL'(1);
    localparam logic signed [FULL-1:0] SAT_MIN = -(FULL'(1) <<< (D_BIT - 1));
`endif

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t                state_q, state_d;
    logic [1:0]            cnt_q, cnt_d;
    logic [3*D_BIT-1:0]    x_re_q, x_im_q;
    logic [3*W_BIT-1:0]    w_re_q, w_im_q;
    logic [4*D_BIT-1:0]    y_re_q, y_im_q;
    logic                  accept;

    logic signed [D_BIT-1:0] xr, xi;
    logic signed [W_BIT-1:0] wr, wi;
    logic signed [FULL-1:0]  re_full, im_full;
    logic [D_BIT-1:0]        re_n, im_n;

    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: if (iVALID) begin
                state_d = CALC;
                cnt_d   = 2'd1;
            end
            CALC: if (cnt_q == 2'd3) state_d = DONE;
                  else               cnt_d   = cnt_q + 2'd1;
            DONE: if (iREADY) begin
                if (iVALID) begin
                    state_d = CALC;
                    cnt_d   = 2'd1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        oREADY = (state_q == IDLE) || ((state_q == DONE) && iREADY);
        oVALID = (state_q == DONE);
    end

    assign accept = iVALID && oREADY;

    // Operand select for the single shared multiplier; lane = cnt_q.
    always_comb begin
        unique case (cnt_q)
            2'd2: begin
                xr = x_re_q[D_BIT +: D_BIT];   xi = x_im_q[D_BIT +: D_BIT];
                wr = w_re_q[W_BIT +: W_BIT];   wi = w_im_q[W_BIT +: W_BIT];
            end
            2'd3: begin
                xr = x_re_q[2*D_BIT +: D_BIT]; xi = x_im_q[2*D_BIT +: D_BIT];
                wr = w_re_q[2*W_BIT +: W_BIT]; wi = w_im_q[2*W_BIT +: W_BIT];
            end
            default: begin
                xr = x_re_q[0 +: D_BIT];       xi = x_im_q[0 +: D_BIT];
                wr = w_re_q[0 +: W_BIT];       wi = w_im_q[0 +: W_BIT];
            end
        endcase
        re_full = FULL'(xr) * FULL'(wr) - FULL'(xi) * FULL'(wi);
        im_full = FULL'(xr) * FULL'(wi) + FULL'(xi) * FULL'(wr);
    end

`ifdef FFT_MULT_SAT_EN
    logic signed [FULL-1:0] re_rnd, im_rnd;
    always_comb begin
        re_rnd = (re_full + RND) >>> W_SHIFT;
        im_rnd = (im_full + RND) >>> W_SHIFT;
        if (re_rnd > SAT_MAX)      re_n = D_BIT'(SAT_MAX);
        else if (re_rnd < SAT_MIN) re_n = D_BIT'(SAT_MIN);
        else                       re_n = D_BIT'(re_rnd);
        if (im_rnd > SAT_MAX)      im_n = D_BIT'(SAT_MAX);
        else if (im_rnd < SAT_MIN) im_n = D_BIT'(SAT_MIN);
        else                       im_n = D_BIT'(im_rnd);
    end
`else
    always_comb begin
        re_n = D_BIT'((re_full + RND) >>> W_SHIFT);
        im_n = D_BIT'((im_full + RND) >>> W_SHIFT);
    end
`endif

    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            x_re_q <= '0;
            x_im_q <= '0;
            w_re_q <= '0;
            w_im_q <= '0;
            y_re_q <= '0;
            y_im_q <= '0;
        end else begin
            if (accept) begin
                x_re_q <= iX_RE[4*D_BIT-1:D_BIT];
                x_im_q <= iX_IM[4*D_BIT-1:D_BIT];
                w_re_q <= iW_RE;
                w_im_q <= iW_IM;
                y_re_q[0 +: D_BIT] <= iX_RE[0 +: D_BIT];
                y_im_q[0 +: D_BIT] <= iX_IM[0 +: D_BIT];
            end
            if (state_q == CALC) begin
                unique case (cnt_q)
                    2'd2: begin
                        y_re_q[2*D_BIT +: D_BIT] <= re_n;
                        y_im_q[2*D_BIT +: D_BIT] <= im_n;
                    end
                    2'd3: begin
                        y_re_q[3*D_BIT +: D_BIT] <= re_n;
                        y_im_q[3*D_BIT +: D_BIT] <= im_n;
                    end
                    default: begin
                        y_re_q[D_BIT +: D_BIT] <= re_n;
                        y_im_q[D_BIT +: D_BIT] <= im_n;
                    end
                endcase
            end
        end
    end

    assign oY_RE = y_re_q;
    assign oY_IM = y_im_q;

endmodule

// File: tb/tb_fft_mult_block_seq.sv
// Directed testbench for fft_mult_block_seq (default parameters).
module tb_fft_mult_block_seq;

    localparam int D = 17;
    localparam int W = 12;

    logic           iCLK = 1'b0;
    logic           iRESET, iVALID, oREADY, oVALID, iREADY;
    logic [4*D-1:0] iX_RE, iX_IM, oY_RE, oY_IM;
    logic [3*W-1:0] iW_RE, iW_IM;

    int vxr[4], vxi[4], vwr[4], vwi[4];
    int er[4], ei[4];
    int n_checks = 0;
    int n_fail   = 0;

    fft_mult_block_seq #(.D_BIT(D), .W_BIT(W), .W_SHIFT(W-2)) dut (
        .iCLK(iCLK), .iRESET(iRESET), .iVALID(iVALID), .oREADY(oREADY),
        .iX_RE(iX_RE), .iX_IM(iX_IM), .iW_RE(iW_RE), .iW_IM(iW_IM),
        .oVALID(oVALID), .iREADY(iREADY), .oY_RE(oY_RE), .oY_IM(oY_IM)
    );

    always #5 iCLK = ~iCLK;

    function automatic int yre(int k);
        logic [D-1:0] v;
        v = oY_RE[k*D +: D];
        return int'($signed(v));
    endfunction

    function automatic int yim(int k);
        logic [D-1:0] v;
        v = oY_IM[k*D +: D];
        return int'($signed(v));
    endfunction

    task automatic drive_vec();
        for (int k = 0; k < 4; k++) begin
            iX_RE[k*D +: D] = D'(vxr[k]);
            iX_IM[k*D +: D] = D'(vxi[k]);
        end
        for (int k = 1; k < 4; k++) begin
            iW_RE[(k-1)*W +: W] = W'(vwr[k]);
            iW_IM[(k-1)*W +: W] = W'(vwi[k]);
        end
    endtask

    task automatic set_basic();
        vxr = '{7, 1000, 100, 3};   vxi = '{-7, 0, 200, 0};
        vwr = '{0, 1024, 0, 512};   vwi = '{0, 0, -1024, 0};
        er  = '{7, 1000, 200, 2};   ei  = '{-7, 0, -100, 0};
    endtask

    task automatic run_to_done();
        @(negedge iCLK);
        drive_vec();
        iVALID = 1'b1;
        iREADY = 1'b0;
        @(negedge iCLK);
        iVALID = 1'b0;
        repeat (3) @(negedge iCLK);
    endtask

    task automatic release_done();
        iREADY = 1'b1;
        @(negedge iCLK);
        iREADY = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        n_checks++;
        if (oVALID !== 1'b0 || oY_RE !== '0 || oY_IM !== '0) begin
            n_fail++;
            $display("FAIL reset_state: oVALID=%b oY_RE=%h oY_IM=%h required 0", oVALID, oY_RE, oY_IM);
        end
        repeat (2) @(negedge iCLK);
        iRESET = 1'b1;
        #1;
        n_checks++;
        if (oREADY !== 1'b1 || oVALID !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: oREADY=%b oVALID=%b required 1/0", oREADY, oVALID);
        end
    endtask

    task automatic test_basic();
        set_basic();
        @(negedge iCLK);
        drive_vec();
        iVALID = 1'b1;
        iREADY = 1'b0;
        n_checks++;
        if (oREADY !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_ready: got %b required 1", oREADY);
        end
        @(negedge iCLK);
        iVALID = 1'b0;
        vxr = '{12345, -222, 333, -444}; vxi = '{555, 666, -777, 888};
        vwr = '{0, 99, -99, 77};         vwi = '{0, -55, 44, 33};
        drive_vec();
        for (int e = 1; e <= 4; e++) begin
            n_checks++;
            if (oVALID !== (e == 4)) begin
                n_fail++;
                $display("FAIL basic_latency_edge%0d: oVALID=%b required %b", e, oVALID, e == 4);
            end
            if (e < 4) @(negedge iCLK);
        end
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (yre(k) !== er[k] || yim(k) !== ei[k]) begin
                n_fail++;
                $display("FAIL basic_lane%0d: got (%0d,%0d) required (%0d,%0d)", k, yre(k), yim(k), er[k], ei[k]);
            end
        end
        release_done();
        n_checks++;
        if (oVALID !== 1'b0 || oREADY !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_release: oVALID=%b oREADY=%b required 0/1", oVALID, oREADY);
        end
    endtask

    task automatic test_neg_round();
        vxr = '{-65536, 1, -1, -3};  vxi = '{65535, 1, 0, 0};
        vwr = '{0, 1024, 0, 512};    vwi = '{0, 0, 1024, 0};
        er  = '{-65536, 1, 0, -1};   ei  = '{65535, 1, -1, 0};
        run_to_done();
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (yre(k) !== er[k] || yim(k) !== ei[k]) begin
                n_fail++;
                $display("FAIL neground_lane%0d: got (%0d,%0d) required (%0d,%0d)", k, yre(k), yim(k), er[k], ei[k]);
            end
        end
        release_done();
    endtask

    task automatic test_narrow();
        vxr = '{-65536, 65535, -65536, 0}; vxi = '{65535, 0, 0, 0};
        vwr = '{0, 2047, 2047, 0};         vwi = '{0, 0, 0, 0};
`ifdef FFT_MULT_SAT_EN
        er  = '{-65536, 65535, -65536, 0};
`else
        er  = '{-65536, -66, 64, 0};
`endif
        ei  = '{65535, 0, 0, 0};
        run_to_done();
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (yre(k) !== er[k] || yim(k) !== ei[k]) begin
                n_fail++;
                $display("FAIL narrow_lane%0d: got (%0d,%0d) required (%0d,%0d)", k, yre(k), yim(k), er[k], ei[k]);
            end
        end
        release_done();
    endtask

    task automatic test_backpressure();
        set_basic();
        run_to_done();
        for (int i = 0; i < 5; i++) begin
            vxr = '{500 + i, 600, 700, 800}; vxi = '{-1, -2, -3, -4};
            vwr = '{0, 1024, 1024, 1024};    vwi = '{0, 0, 0, 0};
            drive_vec();
            iVALID = 1'b1;
            n_checks++;
            if (oREADY !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_ready_cyc%0d: got %b required 0", i, oREADY);
            end
            @(negedge iCLK);
            n_checks++;
            if (oVALID !== 1'b1) begin
                n_fail++;
                $display("FAIL bp_valid_cyc%0d: got %b required 1", i, oVALID);
            end
            for (int k = 0; k < 4; k++) begin
                n_checks++;
                if (yre(k) !== er[k] || yim(k) !== ei[k]) begin
                    n_fail++;
                    $display("FAIL bp_lane%0d_cyc%0d: got (%0d,%0d) required (%0d,%0d)", k, i, yre(k), yim(k), er[k], ei[k]);
                end
            end
        end
        iVALID = 1'b0;
        release_done();
        n_checks++;
        if (oVALID !== 1'b0 || oREADY !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release: oVALID=%b oREADY=%b required 0/1", oVALID, oREADY);
        end
    endtask

    // Lane1 W=1, lane2 W=j, lane3 W=-1.
    task automatic set_b2b(int v);
        int a;
        a = 37 * (v + 1);
        vxr = '{a, a + 1, a + 3, -(a + 5)};  vxi = '{-a, a + 2, -(a + 4), a + 6};
        vwr = '{0, 1024, 0, -1024};          vwi = '{0, 0, 1024, 0};
    endtask

    task automatic exp_b2b(int v);
        int a;
        a = 37 * (v + 1);
        er = '{a, a + 1, a + 4, a + 5};
        ei = '{-a, a + 2, a + 3, -(a + 6)};
    endtask

    task automatic test_back_to_back();
        logic exp_v;
        iREADY = 1'b1;
        @(negedge iCLK);
        set_b2b(0);
        drive_vec();
        iVALID = 1'b1;
        for (int c = 1; c <= 13; c++) begin
            @(negedge iCLK);
            exp_v = ((c % 4) == 0);
            n_checks++;
            if (oVALID !== exp_v) begin
                n_fail++;
                $display("FAIL b2b_valid_cyc%0d: got %b required %b", c, oVALID, exp_v);
            end
            if (exp_v) begin
                exp_b2b(c / 4 - 1);
                for (int k = 0; k < 4; k++) begin
                    n_checks++;
                    if (yre(k) !== er[k] || yim(k) !== ei[k]) begin
                        n_fail++;
                        $display("FAIL b2b_vec%0d_lane%0d: got (%0d,%0d) required (%0d,%0d)", c / 4 - 1, k, yre(k), yim(k), er[k], ei[k]);
                    end
                end
                n_checks++;
                if (oREADY !== 1'b1) begin
                    n_fail++;
                    $display("FAIL b2b_ready_cyc%0d: got %b required 1", c, oREADY);
                end
                if (c / 4 < 3) begin
                    set_b2b(c / 4);
                    drive_vec();
                end else begin
                    iVALID = 1'b0;
                end
            end
        end
        iREADY = 1'b0;
    endtask

    task automatic test_reset_mid_calc();
        set_basic();
        @(negedge iCLK);
        drive_vec();
        iVALID = 1'b1;
        @(negedge iCLK);
        iVALID = 1'b0;
        @(posedge iCLK);
        #2 iRESET = 1'b0;
        #1;
        n_checks++;
        if (oVALID !== 1'b0 || oY_RE !== '0 || oY_IM !== '0) begin
            n_fail++;
            $display("FAIL midreset_clear: oVALID=%b oY_RE=%h oY_IM=%h required 0", oVALID, oY_RE, oY_IM);
        end
        @(negedge iCLK);
        iRESET = 1'b1;
        #1;
        n_checks++;
        if (oREADY !== 1'b1 || oVALID !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_release: oREADY=%b oVALID=%b required 1/0", oREADY, oVALID);
        end
        run_to_done();
        n_checks++;
        if (oVALID !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_valid: got %b required 1", oVALID);
        end
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (yre(k) !== er[k] || yim(k) !== ei[k]) begin
                n_fail++;
                $display("FAIL midreset_lane%0d: got (%0d,%0d) required (%0d,%0d)", k, yre(k), yim(k), er[k], ei[k]);
            end
        end
        release_done();
    endtask

    initial begin
        iRESET = 1'b0;
        iVALID = 1'b0;
        iREADY = 1'b0;
        iX_RE  = '0;
        iX_IM  = '0;
        iW_RE  = '0;
        iW_IM  = '0;
        test_reset();
        test_basic();
        test_neg_round();
        test_narrow();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_calc();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
